mux_rr_arbiter: RTL and testbench
=================================

MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
REQ-001 Parameter width, default 4, is the data width of each input and of the output.
REQ-002 Parameter swidth, default 3, is the select width; the block serves 2**swidth = 8 requesters.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i0..i7  input  width each  requester data words.
REQ-006 req  input  8  request per requester; bit n belongs to in.
REQ-007 o  output  width  registered output data.
REQ-008 o_valid  output  1  o holds a granted word.
REQ-009 o_ready  input  1  downstream accepts o when o_valid && o_ready.
REQ-010 sel  output  swidth  index of the current or most recent grant.
REQ-011 gnt  output  8  one-hot grant; all zero when idle.
REQ-012 ack  output  8  one-cycle pulse to the requester whose word was accepted.

Function
REQ-013 The FSM SHALL have two states: IDLE (o_valid=0) and BUSY (o_valid=1).
REQ-014 The arbiter SHALL keep a 3-bit pointer ptr and grant the first set req bit searching ptr, ptr+1, ..., ptr+7, wrapping mod 8.
REQ-015 IDLE with req!=0: at the next edge go BUSY, o<=i[winner], sel<=winner, gnt<=onehot(winner), o_valid<=1; latency is one cycle from req to o_valid.
REQ-016 IDLE with req==0: all outputs hold; gnt stays 0.
REQ-017 BUSY without o_ready: o, sel, gnt and o_valid SHALL hold; changes on req or data are ignored.
REQ-018 BUSY with o_ready: ack[sel] pulses for one cycle; ptr<=sel+1 (7 wraps to 0).
REQ-019 On a BUSY transfer with another req bit set (req[sel] excluded), the next winner SHALL be chosen from the updated ptr in the same cycle; BUSY persists back-to-back with no idle bubble.
REQ-020 On a BUSY transfer with no other eligible request, go IDLE; o_valid<=0, gnt<=0, and o and sel hold their last values.
REQ-021 Data SHALL be captured only at grant; a requester dropping req while granted still completes its transfer and receives ack.
REQ-022 Requesters SHALL hold req until ack; the same requester is not re-granted in the ack cycle (except under REQ-027).
REQ-023 No requester SHALL wait more than 7 other grants while its req is held.

Reset
REQ-024 On rst_n low, asynchronously: state=IDLE, ptr=0, o=0, o_valid=0, sel=0, gnt=0, ack=0.
REQ-025 Reset mid-transfer SHALL drop the pending word; no ack is issued; arbitration resumes from ptr=0 after release.

Configuration
REQ-026 Macro MUX_RR_BURST_EN selects burst hold.
REQ-027 With MUX_RR_BURST_EN defined: if req[sel] is still set at transfer, the same requester is re-granted with the new data, ptr is not advanced, and the burst is capped at 4 consecutive words, after which REQ-018/019 rules apply.
REQ-028 Without MUX_RR_BURST_EN: strict one word per grant per REQ-018..022; no burst counter is synthesized.

Verification
REQ-029 Reset then req=8'h01, i0=4'hA, o_ready=1 -> one cycle later o=A, sel=0, gnt=8'h01, o_valid=1; ack=8'h01 on the transfer edge.
REQ-030 req=8'hFF held, o_ready=1, ix=x -> grants 0,1,...,7,0 back-to-back with o=0,1,...,7; o_valid is never deasserted.
REQ-031 ptr=6, req=8'h41 -> grant 6 then 0 (wrap); ack pulses 8'h40 then 8'h01.
REQ-032 Granted i2=4'hC with o_ready=0 for 5 cycles while i2 changes to 4'h3 and req2 drops -> o stays C, gnt stays 8'h04; ack[2] asserts on the cycle o_ready rises.
REQ-033 rst_n low while BUSY with o=4'hD -> o=0, o_valid=0, gnt=0 immediately; no ack.
REQ-034 With MUX_RR_BURST_EN and req=8'h03 held -> requester 0 granted 4 consecutive words, then requester 1; without the macro -> alternates 0,1,0,1.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: 8-way round-robin arbiter that registers the granted word
// and holds it until the downstream side accepts it (o_valid && o_ready).
// Optional feature macro MUX_RR_BURST_EN: when defined, a requester that still
// asserts req at its transfer is re-granted for up to 4 consecutive words.
module mux_rr_arbiter #(
    parameter int width  = 4,
    parameter int swidth = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [width-1:0]      i0,
    input  logic [width-1:0]      i1,
    input  logic [width-1:0]      i2,
    input  logic [width-1:0]      i3,
    input  logic [width-1:0]      i4,
    input  logic [width-1:0]      i5,
    input  logic [width-1:0]      i6,
    input  logic [width-1:0]      i7,
    input  logic [2**swidth-1:0]  req,
    output logic [width-1:0]      o,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic [swidth-1:0]     sel,
    output logic [2**swidth-1:0]  gnt,
    output logic [2**swidth-1:0]  ack
);

    localparam int NREQ = 2**swidth;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                 state_q;
    logic [swidth-1:0]      ptr_q;
    logic [width-1:0]       o_q;
    logic [swidth-1:0]      sel_q;
    logic [NREQ-1:0]        gnt_q;
    logic                   valid_q;

`ifdef MUX_RR_BURST_EN
    localparam int BURST_MAX = 4;
    logic [2:0]             burstCnt_q;
`endif

    logic [width-1:0]       inArr [NREQ];
    logic [swidth-1:0]      searchStart_d;
    logic [NREQ-1:0]        searchReq_d;
    logic [swidth-1:0]      cand_d;
    logic                   winHit_d;
    logic [swidth-1:0]      winIdx_d;

    assign inArr[0] = i0;
    assign inArr[1] = i1;
    assign inArr[2] = i2;
    assign inArr[3] = i3;
    assign inArr[4] = i4;
    assign inArr[5] = i5;
    assign inArr[6] = i6;
    assign inArr[7] = i7;

    // Pick the next winner: from ptr when idle, or from just after the current
    // grant (current requester excluded) when a transfer completes while busy.
    always_comb begin
        searchStart_d = (state_q == BUSY) ? sel_q + swidth'(1) : ptr_q;
        searchReq_d   = (state_q == BUSY) ? (req & ~gnt_q) : req;
        cand_d        = '0;
        winHit_d      = 1'b0;
        winIdx_d      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_d = searchStart_d + swidth'(k);
            if (!winHit_d && searchReq_d[cand_d]) begin
                winHit_d = 1'b1;
                winIdx_d = cand_d;
            end
        end
    end

    // Grant/hold/transfer state machine; all outputs except ack are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            o_q        <= '0;
            sel_q      <= '0;
            gnt_q      <= '0;
            valid_q    <= 1'b0;
`ifdef MUX_RR_BURST_EN
            burstCnt_q <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (winHit_d) begin
                        state_q    <= BUSY;
                        o_q        <= inArr[winIdx_d];
                        sel_q      <= winIdx_d;
                        gnt_q      <= NREQ'(1) << winIdx_d;
                        valid_q    <= 1'b1;
`ifdef MUX_RR_BURST_EN
                        burstCnt_q <= 3'd1;
`endif
                    end
                end
                BUSY: begin
                    if (o_ready) begin
`ifdef MUX_RR_BURST_EN
                        if (req[sel_q] && (burstCnt_q < 3'(BURST_MAX))) begin
                            o_q        <= inArr[sel_q];
                            burstCnt_q <= burstCnt_q + 3'd1;
                        end else
`endif
                        begin
                            ptr_q <= sel_q + swidth'(1);
                            if (winHit_d) begin
                                o_q        <= inArr[winIdx_d];
                                sel_q      <= winIdx_d;
                                gnt_q      <= NREQ'(1) << winIdx_d;
`ifdef MUX_RR_BURST_EN
                                burstCnt_q <= 3'd1;
`endif
                            end else begin
                                state_q <= IDLE;
                                valid_q <= 1'b0;
                                gnt_q   <= '0;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o       = o_q;
    assign o_valid = valid_q;
    assign sel     = sel_q;
    assign gnt     = gnt_q;
    assign ack     = (valid_q && o_ready) ? gnt_q : '0;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: scoreboard bench for the round-robin output arbiter.
// Expected grants are queued as stimulus is applied and popped on each
// accepted transfer by the negedge monitor.
module tb_mux_rr_arbiter;

    typedef struct {
        int          idx;
        logic [3:0]  data;
    } sbItem_t;

    logic        clk;
    logic        rst_n;
    logic [3:0]  inData [8];
    logic [7:0]  req;
    logic [3:0]  o;
    logic        o_valid;
    logic        o_ready;
    logic [2:0]  sel;
    logic [7:0]  gnt;
    logic [7:0]  ack;

    sbItem_t     sb [$];
    sbItem_t     expItem;
    logic [7:0]  expAck;
    bit          dropOnAck;
    int          errors;
    int          checks;

    mux_rr_arbiter #(.width(4), .swidth(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i0      (inData[0]),
        .i1      (inData[1]),
        .i2      (inData[2]),
        .i3      (inData[3]),
        .i4      (inData[4]),
        .i5      (inData[5]),
        .i6      (inData[6]),
        .i7      (inData[7]),
        .req     (req),
        .o       (o),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .sel     (sel),
        .gnt     (gnt),
        .ack     (ack)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: on every accepted transfer, pop the scoreboard and compare;
    // models requesters dropping req on ack and stopping once all words are out.
    always @(negedge clk) begin
        if (rst_n && o_valid && o_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_transfer got sel=%0d o=%h exp no transfer", sel, o);
            end else begin
                expItem = sb.pop_front();
                expAck  = 8'b1 << expItem.idx;
                checks++;
                if (sel !== 3'(expItem.idx)) begin
                    errors++;
                    $display("[TB] FAIL xfer_sel got=%0d exp=%0d", sel, expItem.idx);
                end
                checks++;
                if (o !== expItem.data) begin
                    errors++;
                    $display("[TB] FAIL xfer_data got=%h exp=%h", o, expItem.data);
                end
                checks++;
                if (gnt !== expAck) begin
                    errors++;
                    $display("[TB] FAIL xfer_gnt got=%h exp=%h", gnt, expAck);
                end
                checks++;
                if (ack !== expAck) begin
                    errors++;
                    $display("[TB] FAIL xfer_ack got=%h exp=%h", ack, expAck);
                end
            end
            if (dropOnAck) req = req & ~ack;
            if (sb.size() == 0) req = '0;
        end
    end

    // Hard stop so a hung DUT can never stall the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic pushExp(input int idx, input logic [3:0] data);
        sbItem_t item;
        item.idx  = idx;
        item.data = data;
        sb.push_back(item);
    endtask

    task automatic doReset();
        rst_n     = 1'b0;
        req       = '0;
        o_ready   = 1'b0;
        dropOnAck = 1'b1;
        for (int k = 0; k < 8; k++) inData[k] = 4'(k);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic waitDrain(input int maxCycles, output bit drained);
        int n;
        n = 0;
        while (sb.size() != 0 && n < maxCycles) begin
            @(posedge clk);
            #1;
            n++;
        end
        drained = (sb.size() == 0);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 8'hFF;
        o_ready = 1'b1;
        #3;
        checks++;
        if ({o, o_valid, sel, gnt, ack} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got o=%h v=%b sel=%0d gnt=%h ack=%h exp all zero",
                     o, o_valid, sel, gnt, ack);
        end
        doReset();
        checks++;
        if (o_valid !== 1'b0 || gnt !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_idle got v=%b gnt=%h exp v=0 gnt=00", o_valid, gnt);
        end
    endtask

    task automatic test_single();
        bit drained;
        doReset();
        pushExp(0, 4'hA);
        inData[0] = 4'hA;
        o_ready   = 1'b1;
        req       = 8'h01;
        @(posedge clk);
        #1;
        checks++;
        if (o !== 4'hA || sel !== 3'd0 || gnt !== 8'h01 || o_valid !== 1'b1 || ack !== 8'h01) begin
            errors++;
            $display("[TB] FAIL single_grant got o=%h sel=%0d gnt=%h v=%b ack=%h exp o=a sel=0 gnt=01 v=1 ack=01",
                     o, sel, gnt, o_valid, ack);
        end
        waitDrain(5, drained);
        checks++;
        if (!drained) begin
            errors++;
            $display("[TB] FAIL single_drain got pending=%0d exp 0", sb.size());
        end
        checks++;
        if (o_valid !== 1'b0 || gnt !== 8'h00 || o !== 4'hA || sel !== 3'd0) begin
            errors++;
            $display("[TB] FAIL single_idle_hold got v=%b gnt=%h o=%h sel=%0d exp v=0 gnt=00 o=a sel=0",
                     o_valid, gnt, o, sel);
        end
    endtask

    task automatic test_back_to_back();
        int  bubbles;
        int  n;
        bit  seen;
        doReset();
        dropOnAck = 1'b0;
        o_ready   = 1'b1;
`ifdef MUX_RR_BURST_EN
        for (int k = 0; k < 4; k++) pushExp(0, 4'h0);
        for (int k = 0; k < 4; k++) pushExp(1, 4'h1);
        pushExp(2, 4'h2);
`else
        for (int k = 0; k < 8; k++) pushExp(k, 4'(k));
        pushExp(0, 4'h0);
`endif
        req     = 8'hFF;
        bubbles = 0;
        seen    = 1'b0;
        n       = 0;
        while (sb.size() != 0 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
            if (o_valid) seen = 1'b1;
            if (seen && !o_valid && sb.size() != 0) bubbles++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL b2b_drain got pending=%0d exp 0", sb.size());
        end
        checks++;
        if (bubbles != 0) begin
            errors++;
            $display("[TB] FAIL b2b_bubbles got=%0d exp=0", bubbles);
        end
        @(posedge clk);
        #1;
        checks++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_end_idle got v=%b exp v=0", o_valid);
        end
    endtask

    task automatic test_wrap();
        bit drained;
        doReset();
        o_ready = 1'b1;
        pushExp(5, 4'h5);
        req = 8'h20;
        waitDrain(10, drained);
        checks++;
        if (!drained) begin
            errors++;
            $display("[TB] FAIL wrap_setup got pending=%0d exp 0", sb.size());
        end
        pushExp(6, 4'h6);
        pushExp(0, 4'h0);
        req = 8'h41;
        waitDrain(10, drained);
        checks++;
        if (!drained) begin
            errors++;
            $display("[TB] FAIL wrap_drain got pending=%0d exp 0", sb.size());
        end
    endtask

    task automatic test_hold();
        bit drained;
        int bad;
        doReset();
        o_ready   = 1'b0;
        inData[2] = 4'hC;
        pushExp(2, 4'hC);
        req = 8'h04;
        @(posedge clk);
        #1;
        inData[2] = 4'h3;
        req       = 8'h00;
        bad       = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            if (o !== 4'hC || gnt !== 8'h04 || o_valid !== 1'b1 || ack !== 8'h00) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL hold_stable got bad_cycles=%0d o=%h gnt=%h exp 0 o=c gnt=04", bad, o, gnt);
        end
        o_ready = 1'b1;
        #1;
        checks++;
        if (ack !== 8'h04) begin
            errors++;
            $display("[TB] FAIL hold_ack got=%h exp=04", ack);
        end
        waitDrain(5, drained);
        checks++;
        if (!drained || o_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hold_drain got pending=%0d v=%b exp 0 v=0", sb.size(), o_valid);
        end
    endtask

    task automatic test_reset_mid();
        bit drained;
        doReset();
        o_ready = 1'b1;
        pushExp(5, 4'h5);
        req = 8'h20;
        waitDrain(10, drained);
        o_ready   = 1'b0;
        inData[3] = 4'hD;
        req       = 8'h08;
        @(posedge clk);
        #1;
        checks++;
        if (o !== 4'hD || gnt !== 8'h08 || o_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midrst_grant got o=%h gnt=%h v=%b exp o=d gnt=08 v=1", o, gnt, o_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (o !== 4'h0 || o_valid !== 1'b0 || gnt !== 8'h00) begin
            errors++;
            $display("[TB] FAIL midrst_clear got o=%h v=%b gnt=%h exp o=0 v=0 gnt=00", o, o_valid, gnt);
        end
        o_ready = 1'b1;
        #1;
        checks++;
        if (ack !== 8'h00) begin
            errors++;
            $display("[TB] FAIL midrst_ack got=%h exp=00", ack);
        end
        pushExp(3, 4'hD);
        pushExp(7, 4'h7);
        req = 8'h88;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        waitDrain(10, drained);
        checks++;
        if (!drained) begin
            errors++;
            $display("[TB] FAIL midrst_resume got pending=%0d exp 0", sb.size());
        end
    endtask

    task automatic test_burst();
        bit drained;
        doReset();
        dropOnAck = 1'b0;
        o_ready   = 1'b1;
        inData[0] = 4'h1;
        inData[1] = 4'h2;
`ifdef MUX_RR_BURST_EN
        for (int k = 0; k < 4; k++) pushExp(0, 4'h1);
        pushExp(1, 4'h2);
`else
        pushExp(0, 4'h1);
        pushExp(1, 4'h2);
        pushExp(0, 4'h1);
        pushExp(1, 4'h2);
`endif
        req = 8'h03;
        waitDrain(20, drained);
        checks++;
        if (!drained) begin
            errors++;
            $display("[TB] FAIL burst_drain got pending=%0d exp 0", sb.size());
        end
    endtask

    // Run every scenario in order, then print the summary.
    initial begin
        errors    = 0;
        checks    = 0;
        dropOnAck = 1'b1;
        rst_n     = 1'b1;
        req       = '0;
        o_ready   = 1'b0;
        for (int k = 0; k < 8; k++) inData[k] = 4'(k);
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_wrap();
        test_hold();
        test_reset_mid();
        test_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
